rptr_handler: RTL and testbench

Read-side pointer and status controller for the asynchronous FIFO. Lives in the read clock domain and synchronises the write-side Gray pointer through a two-flop chain. Maintains the binary and Gray read pointers and produces registered empty, almost_empty, fill-level, read-valid and sticky underflow outputs. Memory read address is b_rptr[PTR_WIDTH-1:0]; FIFO depth is 2^PTR_WIDTH.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/rptr_handler.sv | 68 ++++++
 tb/tb_rptr_handler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async FIFO definitions: default pointer width and Gray helpers.
// Helpers work on a wide word; callers cast to their pointer width.
package fifo_pkg;

  localparam int PTR_WIDTH = 6;
  localparam int FN_W = 32;

  function automatic logic [FN_W-1:0] bin2gray(
    input logic [FN_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(
    input logic [FN_W-1:0] g
  );
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, parameterised width, sync active-high reset.
// Shared by both pointer-crossing paths of the async FIFO.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/rptr_handler.sv
// Read-side pointer/status controller of the async FIFO.
// Syncs the Gray write pointer and registers empty/level/underflow.
module rptr_handler
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH,
  parameter int AE_THRESH = 2
) (
  input  logic               rclk,
  input  logic               rst,
  input  logic               r_en,
  input  logic [PTR_WIDTH:0] g_wptr,
  output logic [PTR_WIDTH:0] b_rptr,
  output logic [PTR_WIDTH:0] g_rptr,
  output logic               empty,
  output logic               almost_empty,
  output logic [PTR_WIDTH:0] rd_count,
  output logic               rd_valid,
  output logic               underflow
);

  localparam int W = PTR_WIDTH + 1;
  localparam logic [W-1:0] AE_LVL = W'(AE_THRESH);

  logic [W-1:0] wq2;
  logic [W-1:0] wbin;
  logic [W-1:0] b_next;
  logic [W-1:0] g_next;
  logic [W-1:0] level;
  logic         rd_acc;

  sync_2ff #(
    .WIDTH(W)
  ) u_wsync (
    .clk(rclk),
    .rst(rst),
    .d  (g_wptr),
    .q  (wq2)
  );

  assign wbin   = W'(gray2bin(FN_W'(wq2)));
  assign rd_acc = r_en & ~empty;
  assign b_next = b_rptr + W'(rd_acc);
  assign g_next = W'(bin2gray(FN_W'(b_next)));
  // Modulo subtraction keeps the level right across pointer wrap.
  assign level  = wbin - b_next;

  always_ff @(posedge rclk) begin
    if (rst) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      rd_valid     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      b_rptr       <= b_next;
      g_rptr       <= g_next;
      empty        <= (g_next == wq2);
      almost_empty <= (level <= AE_LVL);
      rd_count     <= level;
      rd_valid     <= rd_acc;
      underflow    <= underflow | (r_en & empty);
    end
  end

endmodule

// File: tb/tb_rptr_handler.sv
// Randomised + directed bench for rptr_handler (PTR_WIDTH=3, AE=2).
// Reference model tracks write/read counts as plain integers.
module tb_rptr_handler;

  localparam int PW = 3;
  localparam int DEPTH = 8;
  localparam int MODP = 16;
  localparam int AE = 2;

  logic          clk;
  logic          rst;
  logic          r_en;
  logic [PW:0]   g_wptr;
  logic [PW:0]   b_rptr;
  logic [PW:0]   g_rptr;
  logic          empty;
  logic          almost_empty;
  logic [PW:0]   rd_count;
  logic          rd_valid;
  logic          underflow;

  int checks = 0;
  int failures = 0;

  // model state: counts are unbounded integers, pointers are count mod 16
  int wtot;
  int r_tot;
  int s1, s2;
  int m_cnt;
  bit m_empty, m_ae, m_valid, m_uf;
  int prev_g;

  rptr_handler #(
    .PTR_WIDTH(PW),
    .AE_THRESH(AE)
  ) dut (
    .rclk        (clk),
    .rst         (rst),
    .r_en        (r_en),
    .g_wptr      (g_wptr),
    .b_rptr      (b_rptr),
    .g_rptr      (g_rptr),
    .empty       (empty),
    .almost_empty(almost_empty),
    .rd_count    (rd_count),
    .rd_valid    (rd_valid),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray(input int v);
    int b;
    b = v % MODP;
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("b_rptr", int'(b_rptr), r_tot % MODP);
    check("g_rptr", int'(g_rptr), gray(r_tot));
    check("empty", int'(empty), int'(m_empty));
    check("rd_count", int'(rd_count), m_cnt);
    check("almost_empty", int'(almost_empty), int'(m_ae));
    check("rd_valid", int'(rd_valid), int'(m_valid));
    check("underflow", int'(underflow), int'(m_uf));
    check("g_step", $countones(g_rptr ^ prev_g[PW:0]), int'(m_valid));
    prev_g = int'(g_rptr);
  endtask

  task automatic model_reset();
    r_tot = 0; s1 = 0; s2 = 0; m_cnt = 0;
    m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;
    wtot = 0;
  endtask

  task automatic do_reset(input int n, input int graw);
    rst = 1'b1;
    r_en = 1'b0;
    g_wptr = graw[PW:0];
    repeat (n) @(posedge clk);
    model_reset();
    @(negedge clk);
    prev_g = 0;
    check_all();
    rst = 1'b0;
    g_wptr = '0;
  endtask

  task automatic step(input bit ren, input int wcnt);
    bit acc;
    int old_s2;
    r_en = ren;
    wtot = wcnt;
    g_wptr = 4'(gray(wcnt));
    @(posedge clk);
    acc = ren && !m_empty;
    m_uf = m_uf || (ren && m_empty);
    m_valid = acc;
    r_tot += int'(acc);
    old_s2 = s2;
    s2 = s1;
    s1 = wcnt;
    m_cnt = old_s2 - r_tot;
    m_empty = (m_cnt == 0);
    m_ae = (m_cnt <= AE);
    @(negedge clk);
    check_all();
    check("inv_empty", int'(empty), int'(rd_count == 0));
  endtask

  initial begin
    rst = 1'b1;
    r_en = 1'b0;
    g_wptr = '0;
    prev_g = 0;
    model_reset();

    do_reset(2, 5);
    check("rst_empty", int'(empty), 1);
    check("rst_count", int'(rd_count), 0);

    // sync latency: write count 3 seen after three edges
    step(0, 3);
    check("lat_n", int'(empty), 1);
    step(0, 3);
    check("lat_n1", int'(empty), 1);
    step(0, 3);
    check("lat_cnt", int'(rd_count), 3);
    check("lat_ae", int'(almost_empty), 0);

    // drain three entries
    step(1, 3);
    check("drain_ae", int'(almost_empty), 1);
    step(1, 3);
    step(1, 3);
    check("drain_empty", int'(empty), 1);
    check("drain_b", int'(b_rptr), 3);
    check("drain_g", int'(g_rptr), 2);

    // underflow sticky
    step(1, 3);
    check("uf_b", int'(b_rptr), 3);
    check("uf_set", int'(underflow), 1);
    step(0, 3);
    step(0, 3);
    check("uf_hold", int'(underflow), 1);

    // full then drain to 8
    do_reset(1, 0);
    for (int i = 1; i <= DEPTH; i++) step(0, i);
    step(0, DEPTH);
    step(0, DEPTH);
    check("full_cnt", int'(rd_count), DEPTH);
    check("full_empty", int'(empty), 0);
    for (int i = 0; i < DEPTH; i++) step(1, DEPTH);
    check("wrap_b", int'(b_rptr), 8);
    check("wrap_g", int'(g_rptr), 12);

    // simultaneous read and write arrival keeps level
    for (int i = 9; i <= 12; i++) step(0, i);
    step(0, 12);
    step(0, 12);
    check("sim_pre", int'(rd_count), 4);
    step(0, 13);
    step(0, 13);
    check("sim_mid", int'(rd_count), 4);
    step(1, 13);
    check("sim_cnt", int'(rd_count), 4);

    // reset mid-operation
    do_reset(1, int'(g_wptr));

    // random traffic with pointer wrap and occasional reset
    for (int c = 0; c < 600; c++) begin
      int w;
      w = wtot;
      if ($urandom_range(63) == 0) begin
        do_reset(1, int'(g_wptr));
      end else begin
        if ((w - r_tot) < DEPTH && $urandom_range(1) == 1) w++;
        step(1'($urandom_range(2) != 0), w);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
